// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: compares operands, picks the next PC,
// flags mispredictions and trains a 2-bit saturating BHT.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int PC_LSB      = 2,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] res_imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    input  logic            res_pred_taken,
    output logic            out_valid,
    output logic            br_taken,
    output logic            mispredict,
    output logic            illegal,
    output logic [XLEN-1:0] redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       r_bht [BHT_ENTRIES];
    logic [IDX_W-1:0] w_pidx;
    logic [IDX_W-1:0] w_ridx;
    logic             w_eq;
    logic             w_lt;
    logic             w_ltu;
    logic             w_taken;
    logic             w_illegal;
    logic             w_mis;
    logic             w_upd;
    logic [XLEN-1:0]  w_seq_pc;
    logic [XLEN-1:0]  w_tgt_pc;
    logic [1:0]       w_cur;
    logic [1:0]       w_nxt;

    logic             r_out_valid;
    logic             r_br_taken;
    logic             r_mispredict;
    logic             r_illegal;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;

    assign w_pidx     = pred_pc[PC_LSB +: IDX_W];
    assign w_ridx     = res_pc[PC_LSB +: IDX_W];
    assign pred_taken = r_bht[w_pidx][1];

    assign w_eq     = (rs1 == rs2);
    assign w_lt     = ($signed(rs1) < $signed(rs2));
    assign w_ltu    = (rs1 < rs2);
    assign w_seq_pc = res_pc + XLEN'(4);
    assign w_tgt_pc = res_pc + res_imm;

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        unique case (1'b1)
            (funct3 == 3'b000): w_taken = w_eq;
            (funct3 == 3'b001): w_taken = !w_eq;
            (funct3 == 3'b100): w_taken = w_lt;
            (funct3 == 3'b101): w_taken = !w_lt;
            (funct3 == 3'b110): w_taken = w_ltu;
            (funct3 == 3'b111): w_taken = !w_ltu;
            default:            w_illegal = 1'b1;
        endcase
    end

    assign w_mis = (w_taken != res_pred_taken);
    assign w_upd = res_valid && !w_illegal;
    assign w_cur = r_bht[w_ridx];

    // Saturating 2-bit counter step
    always_comb begin
        w_nxt = w_cur;
        if (w_taken && (w_cur != 2'b11)) begin
            w_nxt = w_cur + 2'b01;
        end else if (!w_taken && (w_cur != 2'b00)) begin
            w_nxt = w_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_upd) begin
            r_bht[w_ridx] <= w_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid      <= 1'b0;
            r_br_taken       <= 1'b0;
            r_mispredict     <= 1'b0;
            r_illegal        <= 1'b0;
            r_redirect_pc    <= '0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_out_valid <= res_valid;
            if (res_valid) begin
                r_illegal     <= w_illegal;
                r_br_taken    <= w_upd && w_taken;
                r_mispredict  <= w_upd && w_mis;
                r_redirect_pc <= (w_upd && w_taken) ? w_tgt_pc : w_seq_pc;
            end
            if (w_upd) begin
                if (r_branch_cnt != '1) begin
                    r_branch_cnt <= r_branch_cnt + CNT_W'(1);
                end
                if (w_mis && (r_mispredict_cnt != '1)) begin
                    r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign br_taken       = r_br_taken;
    assign mispredict     = r_mispredict;
    assign illegal        = r_illegal;
    assign redirect_pc    = r_redirect_pc;
    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution stage for the RV32 core, with a 2-bit saturating branch history table (BHT). It compares operands for all six conditional branches and computes the corrected next PC. It flags mispredictions against the fetch-stage guess and trains the BHT, which the fetch stage reads combinationally. Results are registered, so the block sits between execute and the PC-select mux.

## Interface
Parameters:
- XLEN, 32, operand/PC width
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, ≥2
- PC_LSB, 2, lowest PC bit used for BHT index
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- pred_pc  in  XLEN  fetch PC to look up
- pred_taken  out  1  MSB of BHT[idx(pred_pc)], combinational
- res_valid  in  1  a branch is presented for resolution this cycle
- res_pc  in  XLEN  PC of the branch
- res_imm  in  XLEN  sign-extended B-type offset
- rs1, rs2  in  XLEN  operands
- funct3  in  3  branch kind
- res_pred_taken  in  1  prediction fetch used for this branch
- out_valid  out  1  registered result valid
- br_taken  out  1  registered branch outcome
- mispredict  out  1  registered br_taken ≠ res_pred_taken
- illegal  out  1  registered: funct3 was 010 or 011
- redirect_pc  out  XLEN  registered correct next PC
- branch_cnt  out  CNT_W  legal branches resolved
- mispredict_cnt  out  CNT_W  mispredictions

## Operation
- idx(p) = p[PC_LSB +: $clog2(BHT_ENTRIES)].
- Branch kinds by funct3:
  - 000 BEQ, 001 BNE
  - 100 BLT, 101 BGE (signed)
  - 110 BLTU, 111 BGEU (unsigned)
  - 010/011 are illegal.
- The comparison is XLEN-wide.
- Taken target = res_pc + res_imm, truncated to XLEN (wraps modulo 2^XLEN).
- Not-taken target = res_pc + 4, also wrapping.
- On a clock edge with res_valid=1 and legal funct3:
  - out_valid←1, br_taken←outcome, mispredict←(outcome ≠ res_pred_taken), illegal←0, redirect_pc←target.
  - BHT[idx(res_pc)] increments if taken (saturates at 2'b11), decrements if not taken (saturates at 2'b00).
  - branch_cnt increments; mispredict_cnt increments if mispredicted. Both saturate at all-ones and never wrap.
- On a clock edge with res_valid=1 and illegal funct3:
  - out_valid←1, illegal←1, br_taken←0, mispredict←0, redirect_pc←res_pc+4.
  - No BHT update, no counter change.
- On a clock edge with res_valid=0: out_valid←0. Other outputs hold their previous values.
- pred_taken = BHT[idx(pred_pc)][1]. Counter states 10 and 11 predict taken.

## Timing
- Reset (async, immediate):
  - out_valid, br_taken, mispredict, illegal = 0; redirect_pc = 0; both counters = 0.
  - Every BHT entry = 2'b01 (weakly not-taken), so pred_taken = 0 everywhere.
- Resolve latency: inputs sampled on edge N, outputs visible after edge N. out_valid is a 1-cycle pulse per accepted branch. Back-to-back branches are accepted every cycle; there is no backpressure.
- BHT read/write collision: if pred_pc and res_pc index the same entry in the same cycle, pred_taken reflects the pre-update value. The new value is visible from the next cycle.
- Consecutive updates to one entry in adjacent cycles each apply in order. No update is lost.
- Reset asserted mid-stream discards the in-flight result. out_valid is 0 on the first cycle after deassertion unless res_valid is sampled at that edge.
- Distinct PCs aliasing to one index share a counter by design.

## Test plan
- Reset, then sweep pred_pc over all indices → pred_taken=0 everywhere. After one clean edge with res_valid=0, all outputs are 0.
- BLT with rs1=0xFFFFFFFF, rs2=1, res_pc=0x100, imm=0x20, res_pred_taken=0 → next cycle out_valid=1, br_taken=1, mispredict=1, redirect_pc=0x120, branch_cnt=1, mispredict_cnt=1. The same operands with BLTU → br_taken=0, redirect_pc=0x104.
- Taken BEQ at pc=0x40 four times back-to-back → entry walks 01→10→11→11. pred_taken for pred_pc=0x40 reads 1 from the cycle after the first update. Two not-taken resolves → 11→10→01, pred_taken=0.
- funct3=010 with res_valid=1 → illegal=1, br_taken=0, mispredict=0, redirect_pc=pc+4. BHT and counters unchanged.
- res_pc=0xFFFFFFF0, imm=0x20, BGEU with rs1=rs2 → redirect_pc=0x00000010 (wrap). Not taken at pc=0xFFFFFFFC → redirect_pc=0x0.
- pred_pc=res_pc=0x80 in the same cycle as a taken resolve on entry 01 → pred_taken=0 that cycle, 1 the next. Assert rst mid-stream → outputs and BHT return to reset values immediately.
